regfile_write_arbiter: RTL and testbench

Shares the register file's two write ports (write_address/write_data/write_enable and write_address2/write_data2/write_enable2) and its pc update channel among four write-back requesters: ALU, multiplier, load unit and branch-link. Each clock it picks up to two general-register writes and one R15 write in round-robin order. It issues them as registered, single-cycle enable pulses and returns a per-requester ack pulse. It sits between the execute/write-back units and register_file, and is the only driver of the register file's write-side inputs.

---
 rtl/regfile_write_arbiter.sv | 163 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Write-back arbiter for the register file: up to two GPR writes plus one R15 write per cycle,
// round-robin among four requesters. Optional macro WARB_PC_REDIRECT_EN routes R15 to the pc channel.
module regfile_write_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_stall,
  input  logic [3:0]     i_req_valid,
  input  logic [15:0]    i_req_addr,
  input  logic [4*N-1:0] i_req_data,
  output logic [3:0]     o_req_ack,
  output logic [3:0]     o_write_address,
  output logic [N-1:0]   o_write_data,
  output logic           o_write_enable,
  output logic [3:0]     o_write_address2,
  output logic [N-1:0]   o_write_data2,
  output logic           o_write_enable2,
  output logic [N-1:0]   o_pc_update,
  output logic           o_pc_write
);

  logic [1:0]   r_ptr;
  logic [3:0]   r_req_ack;
  logic [3:0]   r_wa;
  logic [N-1:0] r_wd;
  logic         r_we;
  logic [3:0]   r_wa2;
  logic [N-1:0] r_wd2;
  logic         r_we2;

  logic [3:0]   w_elig;
  logic [1:0]   w_idx;
  logic [3:0]   w_addr;
  logic         w_take;
  logic         w_p1_gnt;
  logic [1:0]   w_p1_sel;
  logic [3:0]   w_p1_addr;
  logic         w_p2_gnt;
  logic [1:0]   w_p2_sel;
  logic         w_any;
  logic [1:0]   w_first;
  logic [3:0]   w_ack;
`ifdef WARB_PC_REDIRECT_EN
  logic         w_pc_gnt;
  logic [1:0]   w_pc_sel;
  logic [N-1:0] r_pcu;
  logic         r_pcw;
`endif

  // A requester currently being acked still shows its old request; mask it out.
  assign w_elig = i_req_valid & ~r_req_ack & {4{~i_stall}};

  always_comb begin
    w_idx     = 2'd0;
    w_addr    = 4'd0;
    w_take    = 1'b0;
    w_p1_gnt  = 1'b0;
    w_p1_sel  = 2'd0;
    w_p1_addr = 4'd0;
    w_p2_gnt  = 1'b0;
    w_p2_sel  = 2'd0;
    w_any     = 1'b0;
    w_first   = 2'd0;
`ifdef WARB_PC_REDIRECT_EN
    w_pc_gnt  = 1'b0;
    w_pc_sel  = 2'd0;
`endif
    for (int k = 0; k < 4; k++) begin
      w_idx  = r_ptr + 2'(k);
      w_addr = i_req_addr[4*w_idx +: 4];
      w_take = 1'b0;
      if (w_elig[w_idx]) begin
`ifdef WARB_PC_REDIRECT_EN
        if (w_addr == 4'hF) begin
          if (!w_pc_gnt) begin
            w_pc_gnt = 1'b1;
            w_pc_sel = w_idx;
            w_take   = 1'b1;
          end
        end else
`endif
        if (!w_p1_gnt) begin
          w_p1_gnt  = 1'b1;
          w_p1_sel  = w_idx;
          w_p1_addr = w_addr;
          w_take    = 1'b1;
        end else if (!w_p2_gnt && (w_addr != w_p1_addr)) begin
          // Same-address requester is skipped so write order stays well defined.
          w_p2_gnt = 1'b1;
          w_p2_sel = w_idx;
          w_take   = 1'b1;
        end
      end
      if (w_take && !w_any) begin
        w_any   = 1'b1;
        w_first = w_idx;
      end
    end
  end

  always_comb begin
    w_ack = 4'd0;
    if (w_p1_gnt) w_ack[w_p1_sel] = 1'b1;
    if (w_p2_gnt) w_ack[w_p2_sel] = 1'b1;
`ifdef WARB_PC_REDIRECT_EN
    if (w_pc_gnt) w_ack[w_pc_sel] = 1'b1;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr     <= 2'd0;
      r_req_ack <= 4'd0;
      r_wa      <= 4'd0;
      r_wd      <= '0;
      r_we      <= 1'b0;
      r_wa2     <= 4'd0;
      r_wd2     <= '0;
      r_we2     <= 1'b0;
    end else begin
      r_req_ack <= w_ack;
      r_we      <= w_p1_gnt;
      r_we2     <= w_p2_gnt;
      if (w_p1_gnt) begin
        r_wa <= w_p1_addr;
        r_wd <= i_req_data[N*w_p1_sel +: N];
      end
      if (w_p2_gnt) begin
        r_wa2 <= i_req_addr[4*w_p2_sel +: 4];
        r_wd2 <= i_req_data[N*w_p2_sel +: N];
      end
      if (w_any) r_ptr <= w_first + 2'd1;
    end
  end

`ifdef WARB_PC_REDIRECT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pcu <= '0;
      r_pcw <= 1'b0;
    end else begin
      r_pcw <= w_pc_gnt;
      if (w_pc_gnt) r_pcu <= i_req_data[N*w_pc_sel +: N];
    end
  end

  assign o_pc_update = r_pcu;
  assign o_pc_write  = r_pcw;
`else
  assign o_pc_update = '0;
  assign o_pc_write  = 1'b0;
`endif

  assign o_req_ack        = r_req_ack;
  assign o_write_address  = r_wa;
  assign o_write_data     = r_wd;
  assign o_write_enable   = r_we;
  assign o_write_address2 = r_wa2;
  assign o_write_data2    = r_wd2;
  assign o_write_enable2  = r_we2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic vs. a list-based model.
module tb_regfile_write_arbiter;
  localparam int N = 32;
`ifdef WARB_PC_REDIRECT_EN
  localparam bit Redir = 1'b1;
`else
  localparam bit Redir = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall;
  logic [3:0]  va;
  logic [3:0]  ad [4];
  logic [31:0] dt [4];
  logic [15:0]  req_addr;
  logic [127:0] req_data;
  assign req_addr = {ad[3], ad[2], ad[1], ad[0]};
  assign req_data = {dt[3], dt[2], dt[1], dt[0]};

  logic [3:0]  ack, wa, wa2;
  logic [31:0] wd, wd2, pcu;
  logic        we, we2, pcw;

  regfile_write_arbiter #(.N(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_req_valid(va), .i_req_addr(req_addr),
    .i_req_data(req_data), .o_req_ack(ack), .o_write_address(wa), .o_write_data(wd),
    .o_write_enable(we), .o_write_address2(wa2), .o_write_data2(wd2), .o_write_enable2(we2),
    .o_pc_update(pcu), .o_pc_write(pcw)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: expected registered outputs and the round-robin pointer.
  int          m_ptr = 0;
  logic [3:0]  m_ack = '0, m_wa = '0, m_wa2 = '0;
  logic [31:0] m_wd = '0, m_wd2 = '0, m_pcu = '0;
  logic        m_we = 1'b0, m_we2 = 1'b0, m_pcw = 1'b0;
  logic [3:0]  pend;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int order[$];
    int p1, p2, pc, first, r;
    logic [3:0] na;
    if (rst) begin
      m_ptr = 0; m_ack = '0; m_wa = '0; m_wa2 = '0; m_wd = '0; m_wd2 = '0; m_pcu = '0;
      m_we = 1'b0; m_we2 = 1'b0; m_pcw = 1'b0;
      return;
    end
    p1 = -1; p2 = -1; pc = -1; first = -1;
    for (int k = 0; k < 4; k++) begin
      r = (m_ptr + k) % 4;
      if (va[r] && !m_ack[r] && !stall) order.push_back(r);
    end
    foreach (order[j]) begin
      r = order[j];
      if (Redir && ad[r] == 4'd15) begin
        if (pc < 0) pc = r;
      end else if (p1 < 0) p1 = r;
      else if (p2 < 0 && ad[r] != ad[p1]) p2 = r;
    end
    foreach (order[j])
      if (first < 0 && (order[j] == p1 || order[j] == p2 || order[j] == pc)) first = order[j];
    na = '0;
    m_we = (p1 >= 0);
    if (p1 >= 0) begin m_wa = ad[p1]; m_wd = dt[p1]; na[p1] = 1'b1; end
    m_we2 = (p2 >= 0);
    if (p2 >= 0) begin m_wa2 = ad[p2]; m_wd2 = dt[p2]; na[p2] = 1'b1; end
    m_pcw = (pc >= 0);
    if (pc >= 0) begin m_pcu = dt[pc]; na[pc] = 1'b1; end
    m_ack = na;
    if (first >= 0) m_ptr = (first + 1) % 4;
  endtask

  task automatic check_all();
    cmp("ack", 32'(ack), 32'(m_ack));
    cmp("we", 32'(we), 32'(m_we));
    cmp("wa", 32'(wa), 32'(m_wa));
    cmp("wd", wd, m_wd);
    cmp("we2", 32'(we2), 32'(m_we2));
    cmp("wa2", 32'(wa2), 32'(m_wa2));
    cmp("wd2", wd2, m_wd2);
    cmp("pcw", 32'(pcw), 32'(m_pcw));
    cmp("pcu", pcu, m_pcu);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; va = '0; stall = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; va = '0;
    for (int i = 0; i < 4; i++) begin ad[i] = '0; dt[i] = '0; end

    // Reset held with all requesters valid.
    va = 4'b1111;
    for (int i = 0; i < 4; i++) begin ad[i] = 4'(i + 1); dt[i] = 32'(i + 16); end
    cyc(); cyc();
    cmp("rst_ack", 32'(ack), 32'h0);
    cmp("rst_we", 32'({we, we2, pcw}), 32'h0);
    rst = 1'b0;
    cyc();
    cmp("rst_first_grant", 32'(ack), 32'h3);
    va = '0; cyc();

    // Dual issue.
    do_reset();
    va = 4'b0011; ad[0] = 4'd3; dt[0] = 32'hA; ad[1] = 4'd5; dt[1] = 32'hB;
    cyc();
    cmp("dual_wa", 32'(wa), 32'd3);  cmp("dual_wd", wd, 32'hA);
    cmp("dual_wa2", 32'(wa2), 32'd5); cmp("dual_wd2", wd2, 32'hB);
    cmp("dual_ack", 32'(ack), 32'h3);
    va = '0; cyc();
    cmp("idle_hold_wa", 32'(wa), 32'd3);
    cmp("idle_ack", 32'(ack), 32'h0);

    // Same address from two requesters.
    do_reset();
    va = 4'b0011; ad[0] = 4'd7; dt[0] = 32'd1; ad[1] = 4'd7; dt[1] = 32'd2;
    cyc();
    cmp("same1_wd", wd, 32'd1); cmp("same1_ack", 32'(ack), 32'h1); cmp("same1_we2", 32'(we2), 0);
    cyc();
    cmp("same2_wd", wd, 32'd2); cmp("same2_ack", 32'(ack), 32'h2); cmp("same2_wa", 32'(wa), 7);
    va = '0; cyc();

    // R15 write alongside a GPR write.
    do_reset();
    va = 4'b0101; ad[2] = 4'd15; dt[2] = 32'h100; ad[0] = 4'd4; dt[0] = 32'h55;
    cyc();
    cmp("r15_wa", 32'(wa), 32'd4);
    if (Redir) begin
      cmp("r15_pcw", 32'(pcw), 32'd1); cmp("r15_pcu", pcu, 32'h100);
    end else begin
      cmp("r15_wa2", 32'(wa2), 32'd15); cmp("r15_pcw", 32'(pcw), 32'd0);
    end
    va = '0; cyc();

    // Round robin with all four continuously active.
    do_reset();
    va = 4'b1111;
    for (int i = 0; i < 4; i++) begin ad[i] = 4'(3 * i); dt[i] = 32'(100 + i); end
    for (int j = 0; j < 8; j++) begin
      pend = m_ack;
      cyc();
      cmp("rr_ack", 32'(ack), (j % 2 == 1) ? 32'hC : 32'h3);
      for (int i = 0; i < 4; i++)
        if (pend[i]) begin ad[i] = 4'(3 * i + (j % 3)); dt[i] = $urandom; end
    end

    // Stall, then reset right after a grant.
    do_reset();
    va = 4'b1111;
    for (int i = 0; i < 4; i++) begin ad[i] = 4'(i + 8); dt[i] = $urandom; end
    stall = 1'b1;
    repeat (3) begin
      cyc();
      cmp("stall_en", 32'({we, we2, pcw}), 32'h0);
    end
    stall = 1'b0;
    cyc();
    cmp("unstall_ack", 32'(ack), 32'h3);
    rst = 1'b1;
    cyc();
    cmp("midrst_ack", 32'(ack), 32'h0);
    cmp("midrst_we", 32'({we, we2}), 32'h0);
    rst = 1'b0;
    cyc();
    cmp("midrst_ptr0", 32'(ack), 32'h3);
    va = '0; cyc();

    // Random traffic obeying the hold-until-ack protocol.
    for (int n = 0; n < 400; n++) begin
      pend = m_ack;
      cyc();
      for (int i = 0; i < 4; i++)
        if (pend[i] || !va[i]) begin
          va[i] = ($urandom_range(0, 9) < 7);
          ad[i] = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
          dt[i] = $urandom;
        end
      rst   = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 9) == 0);
    end
    rst = 1'b0; stall = 1'b0; va = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
